out_port_sched: RTL and testbench
=================================

# out_port_sched

Output-port scheduler for a NoC router. It shares one outbound byte-serial link among `NUM_REQ` packet queues and selects one queue per packet. It pops the winning queue's head packet, then serializes the 32-bit packet MSB-first over the `free`/`put` link protocol used between router and endpoint. It sits between the per-input fifos and the router's output link.

## Interface
Parameters:
- `NUM_REQ`, 4: number of requesting queues (2..8).
- `IDW`, `$clog2(NUM_REQ)`: grant index width (derived).

Ports:
- `clk`, in, 1: clock. Everything is on the posedge.
- `rst_b`, in, 1: synchronous, active-high reset (asserted = 1). It is sampled only on the clk posedge.
- `req_valid`, in, `NUM_REQ`: queue i is non-empty (fifo `~empty`).
- `req_pkt`, in, `NUM_REQ`×32: head packet of queue i (combinational fifo read data).
- `req_pop`, out, `NUM_REQ`: one-hot, one-cycle pulse that removes the head of queue i (fifo `re`).
- `free_outbound`, in, 1: downstream can accept a packet. It is registered downstream.
- `put_outbound`, out, 1: byte valid on the link.
- `payload_outbound`, out, 8: link byte.
- `grant_id`, out, `IDW`: index of the queue currently being sent.
- `busy`, out, 1: a packet is latched or in flight.

## Operation
- FSM states: `IDLE`, `SEND`, `GAP`.
- `IDLE`:
  - Arbitrate only if `|req_valid && free_outbound`.
  - The winner w is chosen by the arbiter sub-module.
  - In the same cycle: `req_pop[w]=1`, `req_pkt[w]` is latched into the 32-bit shift buffer, and `grant_id<=w`.
  - Next state is `SEND` with beat counter = 0.
  - Otherwise the FSM stays in `IDLE` and `req_pop` is 0.
- `SEND`:
  - `put_outbound=1` and `payload_outbound=buf[31:24]`.
  - The buffer shifts left 8 each cycle and the beat counter increments.
  - Bytes go out in order: [31:24], [23:16], [15:8], [7:0].
  - After beat 3, next state is `GAP`.
  - `free_outbound` is ignored in `SEND`. It is legal for it to fall during `SEND`.
- `GAP`: one cycle with `put_outbound=0`, then `IDLE`. This guarantees `put` is deasserted before the downstream's registered `free` is resampled.
- Round-robin arbitration:
  - The search starts at `last+1` mod `NUM_REQ` and takes the first valid index.
  - `last` updates only on an actual grant.
  - Reset value of `last` is `NUM_REQ-1`, so queue 0 wins first.
- `payload_outbound` is 8'h00 whenever `put_outbound=0`.
- `busy=1` in `SEND` and `GAP`.
- Beat counter is 2 bits and wraps 3→0 on the exit from `SEND`.
- Pointer wrap: index `NUM_REQ-1` is followed by 0.

## Timing
- Reset values:
  - `put_outbound=0`, `payload_outbound=8'h00`, `req_pop=0`, `grant_id=0`, `busy=0`.
  - State is `IDLE`, `last=NUM_REQ-1`, buffer = 0.
- Cycle t is the grant cycle (`IDLE`, valid and free). Pop happens at t. `put` is high for t+1..t+4. `GAP` is t+5. The earliest next grant is t+6.
  - Minimum packet period is 6 cycles.
- `req_valid` changing while not in `IDLE` has no effect. Requests are not latched; the requester must hold `req_valid`.
- If `free_outbound=0` in `IDLE`, there is no pop and no grant. Arbitration resumes in the first `IDLE` cycle with `free=1`.
- Simultaneous valid requests: exactly one pop per grant. `req_pop` is never multi-hot.
- Reset during `SEND` or `GAP`:
  - Next cycle, all outputs take their reset values.
  - The partially sent packet is dropped; the popped packet is not restored.
  - Downstream sees `put` fall early, which is a documented loss.
- Reset asserted in a grant cycle: the pop still reaches the fifo at that edge. The packet is lost, which is documented.

## Configuration
- `OUT_PORT_SCHED_RR_EN`:
  - Defined: round-robin arbitration as above.
  - Undefined: fixed priority, where the lowest valid index always wins and `last` is not implemented.
  - All other behaviour is identical in both builds.

## Structure
- Shared package `noc_pkg` holds:
  - the `sched_state_t` enum {`IDLE`, `SEND`, `GAP`};
  - `PKT_BYTES=4`;
  - `BYTE_W=8`.
- One sub-module, `rr_arbiter`:
  - combinational winner select from `req_valid` and `last`;
  - its `last` register is updated via a grant-enable input.
  - Fixed-priority mode is selected inside it by the macro.
- The FSM, shift buffer and beat counter live in `out_port_sched`.

## Test plan
- Single packet: `req_valid=4'b0001`, `req_pkt[0]=32'hDEADBEEF`, free=1 → `req_pop[0]` at t; `put` t+1..t+4 with bytes DE, AD, BE, EF; `put=0` at t+5; `grant_id=0`.
- Round-robin with all queues valid and free held high → grants 0,1,2,3,0 at t, t+6, t+12, t+18, t+24. Without the macro → grants 0,0,0.
- Backpressure: valid=1, free=0 for 10 cycles → no pop, `put=0`. Free rises at cycle 10 → pop at cycle 10, first byte at cycle 11.
- Free drops during `SEND` beat 1 → all 4 beats are still sent, then `GAP`. The next grant waits for free=1.
- Reset mid-packet: assert `rst_b` at beat 2 → next cycle `put=0`, `payload=00`, `busy=0`, state `IDLE`. First post-reset grant goes to queue 0.
- Sparse wrap with `NUM_REQ=4`: valid=4'b1001 after a grant to 3 → next grant is 0, then 3.

Source files
------------

// File: rtl/noc_pkg.sv
// Shared NoC router definitions: scheduler state encoding and link framing sizes.
package noc_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        GAP  = 2'd2
    } sched_state_t;

    localparam int PKT_BYTES = 4;
    localparam int BYTE_W    = 8;

endpackage

// File: rtl/out_port_sched_rr_arbiter.sv
// Winner select for the output-port scheduler: round-robin from last grant when
// OUT_PORT_SCHED_RR_EN is defined, otherwise fixed priority (lowest index wins).
module rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int IDW     = $clog2(NUM_REQ)
) (
`ifdef OUT_PORT_SCHED_RR_EN
    input  logic               clk,
    input  logic               rst_b,
    input  logic               grant_en,
`endif
    input  logic [NUM_REQ-1:0] req_valid,
    output logic [IDW-1:0]     winner
);

`ifdef OUT_PORT_SCHED_RR_EN
    logic [IDW-1:0] last;
    logic [IDW-1:0] idx;
    logic           found;

    // Search begins one past the previous winner so every queue gets a turn.
    always_comb begin
        winner = '0;
        idx    = '0;
        found  = 1'b0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            idx = IDW'((int'(last) + k) % NUM_REQ);
            if (!found && req_valid[idx]) begin
                winner = idx;
                found  = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst_b) begin
            last <= IDW'(NUM_REQ - 1);
        end else if (grant_en) begin
            last <= winner;
        end
    end
`else
    always_comb begin
        winner = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (req_valid[k]) begin
                winner = IDW'(k);
            end
        end
    end
`endif

endmodule

// File: rtl/out_port_sched.sv
// NoC output-port scheduler: pops one queue per packet and serializes it MSB-first
// over the free/put link. Arbitration policy selected by OUT_PORT_SCHED_RR_EN.
module out_port_sched
    import noc_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int IDW     = $clog2(NUM_REQ)
) (
    input  logic                  clk,
    input  logic                  rst_b,
    input  logic [NUM_REQ-1:0]    req_valid,
    input  logic [NUM_REQ*32-1:0] req_pkt,
    output logic [NUM_REQ-1:0]    req_pop,
    input  logic                  free_outbound,
    output logic                  put_outbound,
    output logic [7:0]            payload_outbound,
    output logic [IDW-1:0]        grant_id,
    output logic                  busy
);

    localparam int PKT_W = PKT_BYTES * BYTE_W;

    sched_state_t     state;
    logic [PKT_W-1:0] pkt_buf;
    logic [1:0]       beat;
    logic [IDW-1:0]   winner;
    logic             grant;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IDW     (IDW)
    ) u_arb (
`ifdef OUT_PORT_SCHED_RR_EN
        .clk       (clk),
        .rst_b     (rst_b),
        .grant_en  (grant),
`endif
        .req_valid (req_valid),
        .winner    (winner)
    );

    // Pop is combinational so the fifo sees it on the same edge the packet is latched.
    assign grant = (state == IDLE) && (|req_valid) && free_outbound;

    always_comb begin
        req_pop = '0;
        if (grant) begin
            req_pop[winner] = 1'b1;
        end
    end

    assign put_outbound     = (state == SEND);
    assign payload_outbound = put_outbound ? pkt_buf[PKT_W-1 -: BYTE_W] : 8'h00;
    assign busy             = (state != IDLE);

    always_ff @(posedge clk) begin
        if (rst_b) begin
            state    <= IDLE;
            pkt_buf  <= '0;
            beat     <= '0;
            grant_id <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant) begin
                        state    <= SEND;
                        pkt_buf  <= req_pkt[int'(winner)*32 +: 32];
                        grant_id <= winner;
                        beat     <= '0;
                    end
                end
                SEND: begin
                    pkt_buf <= pkt_buf << BYTE_W;
                    beat    <= beat + 2'd1;
                    // GAP drops put before downstream resamples its registered free.
                    if (beat == 2'(PKT_BYTES - 1)) begin
                        state <= GAP;
                    end
                end
                GAP: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_out_port_sched.sv
// Directed bench for out_port_sched; expectations follow OUT_PORT_SCHED_RR_EN
// (round-robin when defined, fixed priority otherwise).
module tb_out_port_sched;

    logic         clk;
    logic         rst_b;
    logic [3:0]   req_valid;
    logic [127:0] req_pkt;
    logic [3:0]   req_pop;
    logic         free_outbound;
    logic         put_outbound;
    logic [7:0]   payload_outbound;
    logic [1:0]   grant_id;
    logic         busy;

    logic [31:0]  pkt [4];
    int           n_checks;
    int           n_fail;

    assign req_pkt = {pkt[3], pkt[2], pkt[1], pkt[0]};

    out_port_sched #(.NUM_REQ(4)) dut (
        .clk              (clk),
        .rst_b            (rst_b),
        .req_valid        (req_valid),
        .req_pkt          (req_pkt),
        .req_pop          (req_pop),
        .free_outbound    (free_outbound),
        .put_outbound     (put_outbound),
        .payload_outbound (payload_outbound),
        .grant_id         (grant_id),
        .busy             (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_b         = 1'b1;
        req_valid     = 4'b0000;
        free_outbound = 1'b0;
        tick();
        tick();
        rst_b = 1'b0;
    endtask

    // Called right after a grant cycle; walks the 4 beats and the gap, ends in IDLE.
    task automatic expect_pkt(input logic [31:0] p, input logic [1:0] gid, input int drop_at);
        for (int b = 0; b < 4; b++) begin
            tick();
            if (b == drop_at) free_outbound = 1'b0;
            #1;
            check("put", 32'(put_outbound), 32'd1);
            check($sformatf("byte%0d", b), 32'(payload_outbound), 32'(p[31-8*b -: 8]));
            check("grant_id", 32'(grant_id), 32'(gid));
            check("busy_send", 32'(busy), 32'd1);
            check("pop_send", 32'(req_pop), 32'd0);
        end
        tick();
        check("gap_put", 32'(put_outbound), 32'd0);
        check("gap_payload", 32'(payload_outbound), 32'd0);
        check("gap_busy", 32'(busy), 32'd1);
        check("gap_pop", 32'(req_pop), 32'd0);
        tick();
    endtask

    initial begin
        logic [1:0] exp;
        n_checks = 0;
        n_fail   = 0;
        pkt[0] = 32'hDEADBEEF;
        pkt[1] = 32'h12345678;
        pkt[2] = 32'hA5C30F96;
        pkt[3] = 32'h0BADF00D;

        do_reset();
        #1;
        check("rst_put", 32'(put_outbound), 32'd0);
        check("rst_payload", 32'(payload_outbound), 32'd0);
        check("rst_pop", 32'(req_pop), 32'd0);
        check("rst_grant_id", 32'(grant_id), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);

        // Single packet
        req_valid     = 4'b0001;
        free_outbound = 1'b1;
        #1;
        check("single_pop", 32'(req_pop), 32'b0001);
        expect_pkt(32'hDEADBEEF, 2'd0, 4);
        req_valid = 4'b0000;
        #1;
        check("idle_busy", 32'(busy), 32'd0);
        check("idle_pop", 32'(req_pop), 32'd0);

        // All queues valid, free held: back-to-back grants every 6 cycles
        do_reset();
        req_valid     = 4'b1111;
        free_outbound = 1'b1;
        for (int g = 0; g < 5; g++) begin
`ifdef OUT_PORT_SCHED_RR_EN
            exp = 2'(g % 4);
`else
            exp = 2'd0;
`endif
            #1;
            check($sformatf("rr_pop%0d", g), 32'(req_pop), 32'd1 << exp);
            expect_pkt(pkt[exp], exp, 4);
        end

        // Backpressure: no pop while free is low
        do_reset();
        req_valid     = 4'b0001;
        free_outbound = 1'b0;
        for (int c = 0; c < 10; c++) begin
            #1;
            check("bp_pop", 32'(req_pop), 32'd0);
            check("bp_put", 32'(put_outbound), 32'd0);
            tick();
        end
        free_outbound = 1'b1;
        #1;
        check("bp_release_pop", 32'(req_pop), 32'b0001);
        expect_pkt(pkt[0], 2'd0, 4);

        // Free falls during beat 1; packet completes, next grant waits for free
        #1;
        check("fd_pop", 32'(req_pop), 32'b0001);
        expect_pkt(pkt[0], 2'd0, 1);
        for (int c = 0; c < 3; c++) begin
            #1;
            check("fd_wait_pop", 32'(req_pop), 32'd0);
            check("fd_wait_put", 32'(put_outbound), 32'd0);
            tick();
        end
        free_outbound = 1'b1;
        #1;
        check("fd_resume_pop", 32'(req_pop), 32'b0001);
        expect_pkt(pkt[0], 2'd0, 4);

        // Reset at beat 2 of a packet from queue 1
        do_reset();
        req_valid     = 4'b0010;
        free_outbound = 1'b1;
        #1;
        check("mr_pop", 32'(req_pop), 32'b0010);
        tick();
        req_valid = 4'b0000;
        tick();
        tick();
        #1;
        check("mr_beat2", 32'(payload_outbound), 32'h56);
        rst_b = 1'b1;
        tick();
        check("mr_put", 32'(put_outbound), 32'd0);
        check("mr_payload", 32'(payload_outbound), 32'd0);
        check("mr_busy", 32'(busy), 32'd0);
        check("mr_grant_id", 32'(grant_id), 32'd0);
        rst_b     = 1'b0;
        req_valid = 4'b1111;
        #1;
        check("mr_first_pop", 32'(req_pop), 32'b0001);
        expect_pkt(pkt[0], 2'd0, 4);

        // Sparse wrap: grant to 3, then valid 1001
        do_reset();
        req_valid     = 4'b1000;
        free_outbound = 1'b1;
        #1;
        check("sw_pop3", 32'(req_pop), 32'b1000);
        expect_pkt(pkt[3], 2'd3, 4);
        req_valid = 4'b1001;
        #1;
        check("sw_pop_wrap", 32'(req_pop), 32'b0001);
        expect_pkt(pkt[0], 2'd0, 4);
`ifdef OUT_PORT_SCHED_RR_EN
        exp = 2'd3;
`else
        exp = 2'd0;
`endif
        #1;
        check("sw_pop_next", 32'(req_pop), 32'd1 << exp);
        expect_pkt(pkt[exp], exp, 4);
        req_valid = 4'b0000;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
